// File: rtl/dm9000a_bus_seq_if.sv
// dm9000a_bus_seq_if: the signal bundle between the DM9000A bus sequencer and its
// neighbours.
//   Host side : iREQ, iWE, iINDEX, iLEN, iWDATA (in)
//               oWREQ, oRDATA, oRVALID, oBUSY, oDONE (out)
//   Pin side  : oDATA, oCMD, oCS_N, oRD_N, oWR_N (out to the pin interface)
//               iDATA (registered read data back from the pin interface)
// The master modport is the sequencer's view. The slave modport is the view of the
// host and pin logic that surrounds it.
interface dm9000a_bus_seq_if #(
  parameter int unsigned LEN_W = 11
);
  logic             iREQ;
  logic             iWE;
  logic [7:0]       iINDEX;
  logic [LEN_W-1:0] iLEN;
  logic [15:0]      iWDATA;
  logic             oWREQ;
  logic [15:0]      oRDATA;
  logic             oRVALID;
  logic             oBUSY;
  logic             oDONE;
  logic [15:0]      oDATA;
  logic             oCMD;
  logic             oCS_N;
  logic             oRD_N;
  logic             oWR_N;
  logic [15:0]      iDATA;

  modport master (
    input  iREQ, iWE, iINDEX, iLEN, iWDATA, iDATA,
    output oWREQ, oRDATA, oRVALID, oBUSY, oDONE,
           oDATA, oCMD, oCS_N, oRD_N, oWR_N
  );

  modport slave (
    output iREQ, iWE, iINDEX, iLEN, iWDATA, iDATA,
    input  oWREQ, oRDATA, oRVALID, oBUSY, oDONE,
           oDATA, oCMD, oCS_N, oRD_N, oWR_N
  );
endinterface

// File: rtl/dm9000a_bus_seq.sv
// dm9000a_bus_seq: converts host register and packet-memory requests into DM9000A
// index/data strobe sequences.
//   iCLK, iRST : clock, and a synchronous active-high reset
//   bus        : dm9000a_bus_seq_if.master, which carries the host request/done
//                handshake, the per-word write-request and read-valid stream, and
//                the pin-interface data, command, chip-select and strobe signals
// Build option: when DM9000A_SEQ_BURST_EN is defined, the sequencer honours iLEN and
// moves up to 2^LEN_W-1 data words for one index phase. When it is not defined,
// every transaction moves one word.
module dm9000a_bus_seq #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned LEN_W      = 11
) (
  input logic                iCLK,
  input logic                iRST,
  dm9000a_bus_seq_if.master  bus
);

  localparam int unsigned SETUP_E  = (SETUP_CYC  < 2) ? 2 : SETUP_CYC;
  localparam int unsigned STROBE_E = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
  localparam int unsigned HOLD_E   = (HOLD_CYC   < 2) ? 2 : HOLD_CYC;
  localparam int unsigned MAX_SH   = (SETUP_E > HOLD_E) ? SETUP_E : HOLD_E;
  localparam int unsigned MAX_E    = (MAX_SH > STROBE_E) ? MAX_SH : STROBE_E;
  localparam int unsigned CNT_W    = $clog2(MAX_E);

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_E - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_E - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_E - 1);
  localparam logic [CNT_W-1:0] HOLD_CAP    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE, IDX_SETUP, IDX_STROBE, IDX_HOLD,
    DAT_SETUP, DAT_STROBE, DAT_HOLD, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q;
  logic [15:0]      data_q;
  logic [15:0]      rdata_q;
  logic             rvalid_q;
  logic             last_word;

  logic             wreq_c, cs_n_c, cmd_c, rd_n_c, wr_n_c;

`ifdef DM9000A_SEQ_BURST_EN
  logic [LEN_W-1:0] words_q;
  assign last_word = (words_q == LEN_W'(1));
`else
  assign last_word = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.iREQ) state_d = IDX_SETUP;
      end
      IDX_SETUP:  if (cnt_q == SETUP_LAST)  begin state_d = IDX_STROBE; cnt_d = '0; end
      IDX_STROBE: if (cnt_q == STROBE_LAST) begin state_d = IDX_HOLD;   cnt_d = '0; end
      IDX_HOLD:   if (cnt_q == HOLD_LAST)   begin state_d = DAT_SETUP;  cnt_d = '0; end
      DAT_SETUP:  if (cnt_q == SETUP_LAST)  begin state_d = DAT_STROBE; cnt_d = '0; end
      DAT_STROBE: if (cnt_q == STROBE_LAST) begin state_d = DAT_HOLD;   cnt_d = '0; end
      DAT_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = last_word ? DONE : DAT_SETUP;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // The strobes and selects are decoded from the state. A synchronous reset of
    // the state therefore releases the bus on the next edge.
    cs_n_c = (state_q == IDLE) || (state_q == DONE);
    cmd_c  = (state_q == DAT_SETUP) || (state_q == DAT_STROBE) || (state_q == DAT_HOLD);
    wr_n_c = !((state_q == IDX_STROBE) || ((state_q == DAT_STROBE) && we_q));
    rd_n_c = !((state_q == DAT_STROBE) && !we_q);
    wreq_c = (state_q == DAT_SETUP) && (cnt_q == '0) && we_q;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      data_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef DM9000A_SEQ_BURST_EN
      words_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.iREQ) begin
            we_q   <= bus.iWE;
            data_q <= {8'h00, bus.iINDEX};
`ifdef DM9000A_SEQ_BURST_EN
            words_q <= (bus.iLEN == '0) ? LEN_W'(1) : bus.iLEN;
`endif
          end
        end
        // The host presents the word one cycle after oWREQ. The word is latched at
        // the end of the last setup cycle, so it reaches the pins as the strobe
        // falls.
        DAT_SETUP: if (we_q && (cnt_q == SETUP_LAST)) data_q <= bus.iWDATA;
        DAT_HOLD: begin
          // The pin interface adds two register stages, so the read word on iDATA
          // is valid in the second hold cycle.
          if (!we_q && (cnt_q == HOLD_CAP)) begin
            rdata_q  <= bus.iDATA;
            rvalid_q <= 1'b1;
          end
`ifdef DM9000A_SEQ_BURST_EN
          if (cnt_q == HOLD_LAST) words_q <= words_q - 1'b1;
`endif
        end
        DONE: data_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.oWREQ   = wreq_c;
  assign bus.oRDATA  = rdata_q;
  assign bus.oRVALID = rvalid_q;
  assign bus.oBUSY   = (state_q != IDLE);
  assign bus.oDONE   = (state_q == DONE);
  assign bus.oDATA   = data_q;
  assign bus.oCMD    = cmd_c;
  assign bus.oCS_N   = cs_n_c;
  assign bus.oRD_N   = rd_n_c;
  assign bus.oWR_N   = wr_n_c;

endmodule
